// File: rtl/fifo_level_pkg.sv
// fifo_level_pkg: shared FIFO defaults and depth helper
package fifo_level_pkg;
  localparam int DEF_B = 8;
  localparam int DEF_W = 4;
  function automatic int depth(input int w);
    return 1 << w;
  endfunction
endpackage

// File: rtl/fifo_level_if.sv
// fifo_level_if: FIFO bus (rd/wr/w_data/clr_err in; r_data, full/empty, almost flags, count, overflow/underflow out)
interface fifo_level_if #(parameter int B = 8, parameter int W = 4);
  logic         rd;
  logic         wr;
  logic [B-1:0] w_data;
  logic         clr_err;
  logic [B-1:0] r_data;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;
  modport master (
    output rd, wr, w_data, clr_err,
    input  r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  rd, wr, w_data, clr_err,
    output r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_level_reg_file.sv
// fifo_level_reg_file: 2**W x B storage, sync write port (wr_en/w_addr/w_data), async read port (r_addr -> r_data)
module fifo_level_reg_file #(parameter int B = 8, parameter int W = 4) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);
  logic [B-1:0] mem [2**W];
  always_ff @(posedge clk)
    if (wr_en) mem[w_addr] <= w_data;
  assign r_data = mem[r_addr];
endmodule

// File: rtl/fifo_level.sv
// fifo_level: show-ahead FIFO with occupancy count, almost flags and sticky overflow/underflow; ports clk, reset (async high), bus (fifo_level_if.slave)
module fifo_level
  import fifo_level_pkg::*;
#(
  parameter int B         = DEF_B,
  parameter int W         = DEF_W,
  parameter int AF_THRESH = depth(W) - 2,
  parameter int AE_THRESH = 1
) (
  input logic        clk,
  input logic        reset,
  fifo_level_if.slave bus
);
  localparam int DEPTH = depth(W);
  logic [W-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         overflow_q, overflow_d, underflow_q, underflow_d;
  logic         wr_acc, rd_acc;
  // a full FIFO still takes a write when a read frees the head slot in the same cycle
  assign wr_acc = bus.wr && (!bus.full || bus.rd);
  assign rd_acc = bus.rd && !bus.empty;
  always_comb begin
    w_ptr_d     = wr_acc ? w_ptr_q + 1'b1 : w_ptr_q;
    r_ptr_d     = rd_acc ? r_ptr_q + 1'b1 : r_ptr_q;
    count_d     = count_q + (W+1)'(wr_acc && !rd_acc) - (W+1)'(rd_acc && !wr_acc);
    overflow_d  = (bus.wr && bus.full && !bus.rd) || (overflow_q && !bus.clr_err);
    underflow_d = (bus.rd && bus.empty) || (underflow_q && !bus.clr_err);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  fifo_level_reg_file #(.B(B), .W(W)) u_rf (
    .clk    (clk),
    .wr_en  (wr_acc),
    .w_addr (w_ptr_q),
    .w_data (bus.w_data),
    .r_addr (r_ptr_q),
    .r_data (bus.r_data)
  );
  assign bus.count        = count_q;
  assign bus.full         = count_q == (W+1)'(DEPTH);
  assign bus.empty        = count_q == '0;
  assign bus.almost_full  = count_q >= (W+1)'(AF_THRESH);
  assign bus.almost_empty = count_q <= (W+1)'(AE_THRESH);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
